// File: rtl/cr_xp10_decomp_crc_chk_pkg.sv
// Shared constants and types for the XP10 decompressor CRC32C check path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cr_xp10_decompPKG;

  localparam logic [31:0] CRC32C_POLY    = 32'h82f6_3b78;
  localparam logic [31:0] CRC32C_SEED    = 32'hffff_ffff;
  localparam logic [31:0] CRC32C_XOR_OUT = 32'hffff_ffff;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } crc_chk_state_e;

  typedef struct packed {
    logic        pass;
    logic        err;
    logic [31:0] crc;
  } crc_chk_result_t;

endpackage

// File: rtl/cr_xp10_decomp_crc32c_step.sv
// Reflected CRC32C update over up to 64 bits of a beat, LSB first (shared with the send side).
// Latency: purely combinational.
// Backpressure: none; sz above 64 simply consumes all 64 bits.
module cr_xp10_decomp_crc32c_step
  import cr_xp10_decompPKG::*;
#(
  parameter logic [31:0] POLY = CRC32C_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [6:0]  sz,
  output logic [31:0] crc_out
);

  logic [31:0] crc;
  logic        fb;

  // Bit-serial LFSR unrolled across the beat; bits at or above sz leave the CRC untouched.
  always_comb begin
    crc = crc_in;
    fb  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) < sz) begin
        fb  = crc[0] ^ data[i];
        crc = {1'b0, crc[31:1]} ^ (fb ? POLY : 32'h0);
      end
    end
    crc_out = crc;
  end

endmodule

// File: rtl/cr_xp10_decomp_crc_chk.sv
// Receive-side CRC32C checker: one registered pass/fail result per framed stream.
// Latency: result valid the cycle after the accepted eof beat; one beat per cycle.
// Backpressure: in_ready drops only while a result is held unconsumed (chk_valid && !chk_ready).
// Optional: CR_XP10_DECOMP_CRC_CHK_STATS_EN adds stat_clr / stat_frames / stat_fails.
module cr_xp10_decomp_crc_chk
  import cr_xp10_decompPKG::*;
#(
  parameter logic [31:0] POLY    = CRC32C_POLY,
  parameter logic [31:0] SEED    = CRC32C_SEED,
  parameter logic [31:0] XOR_OUT = CRC32C_XOR_OUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic [63:0] in_data,
  input  logic [6:0]  in_sz,
  input  logic [31:0] in_exp_crc,
  output logic        chk_valid,
  input  logic        chk_ready,
  output logic        chk_pass,
  output logic [31:0] chk_crc,
  output logic        chk_err
`ifdef CR_XP10_DECOMP_CRC_CHK_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_fails
`endif
);

  crc_chk_state_e  state_r, state_nxt;
  crc_chk_result_t res_r;
  logic            chk_valid_r;
  logic [31:0]     crc_r;
  logic            err_pending_r;

  logic [31:0]     crc_base;
  logic [31:0]     crc_step;
  logic [31:0]     crc_fin;
  logic            accept;
  logic            beat_use;
  logic            beat_err;
  logic            err_all;
  logic            res_load;
  logic            res_xfer;

  assign in_ready = !chk_valid_r || chk_ready;
  assign accept   = in_valid && in_ready;
  assign res_xfer = chk_valid_r && chk_ready;

  // A beat contributes to the CRC only if it opens a frame or lands inside one;
  // stray beats in IDLE are dropped but poison the next result.
  assign beat_use = accept && (in_sof || (state_r == ACCUM));
  assign beat_err = (in_sz > 7'd64) || ((state_r == ACCUM) && in_sof);
  assign err_all  = err_pending_r || beat_err;
  assign res_load = beat_use && in_eof;

  // sof always restarts from SEED, which is also how an abandoned frame is discarded.
  assign crc_base = in_sof ? SEED : crc_r;
  assign crc_fin  = crc_step ^ XOR_OUT;

  cr_xp10_decomp_crc32c_step #(
    .POLY (POLY)
  ) u_step (
    .crc_in  (crc_base),
    .data    (in_data),
    .sz      (in_sz),
    .crc_out (crc_step)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state: open on sof without eof, close on any used eof.
  always_comb begin
    state_nxt = state_r;
    if (accept) begin
      case (state_r)
        IDLE:    if (in_sof && !in_eof) state_nxt = ACCUM;
        ACCUM:   if (in_eof)            state_nxt = IDLE;
        default:                        state_nxt = IDLE;
      endcase
    end
  end

  // Running CRC, sticky error and the held result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r         <= SEED;
      err_pending_r <= 1'b0;
      chk_valid_r   <= 1'b0;
      res_r         <= '0;
    end else begin
      if (res_xfer) begin
        chk_valid_r <= 1'b0;
      end
      if (res_load) begin
        // in_ready guarantees any previous result is gone or leaving this cycle.
        chk_valid_r   <= 1'b1;
        res_r.crc     <= crc_fin;
        res_r.err     <= err_all;
        res_r.pass    <= (crc_fin == in_exp_crc) && !err_all;
        err_pending_r <= 1'b0;
        crc_r         <= SEED;
      end else if (beat_use) begin
        crc_r         <= crc_step;
        err_pending_r <= err_all;
      end else if (accept) begin
        err_pending_r <= 1'b1;
      end
    end
  end

  assign chk_valid = chk_valid_r;
  assign chk_pass  = res_r.pass;
  assign chk_err   = res_r.err;
  assign chk_crc   = res_r.crc;

`ifdef CR_XP10_DECOMP_CRC_CHK_STATS_EN
  logic [31:0] stat_frames_r;
  logic [31:0] stat_fails_r;

  // Saturating transfer counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_r <= '0;
      stat_fails_r  <= '0;
    end else if (stat_clr) begin
      stat_frames_r <= '0;
      stat_fails_r  <= '0;
    end else if (res_xfer) begin
      if (stat_frames_r != 32'hffff_ffff) stat_frames_r <= stat_frames_r + 32'd1;
      if (!res_r.pass && (stat_fails_r != 32'hffff_ffff)) stat_fails_r <= stat_fails_r + 32'd1;
    end
  end

  assign stat_frames = stat_frames_r;
  assign stat_fails  = stat_fails_r;
`endif

endmodule

// File: doc/cr_xp10_decomp_crc_chk.md
Name: cr_xp10_decomp_crc_chk

Overview:
- Receive-side CRC32C checker for the XP10 decompressor.
- Accumulates a running CRC32C over a framed stream of 64-bit beats with bit-granular valid size.
- At end of frame, compares the finalized CRC against the expected CRC carried with the last beat and emits one registered pass/fail result per frame.
- Sits after the frame engine, ahead of the status/response path.

Parameters:
- POLY, 32'h82f63b78, reflected CRC32C polynomial.
- SEED, 32'hffff_ffff, CRC initial value loaded at start of frame.
- XOR_OUT, 32'hffff_ffff, final XOR applied before compare.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  checker can accept a beat
- in_sof  input  1  first beat of frame
- in_eof  input  1  last beat of frame
- in_data  input  64  beat data; byte 0 at [7:0], processed LSB first
- in_sz  input  7  number of valid bits, 0..64, counted from bit 0
- in_exp_crc  input  32  expected finalized CRC; sampled only on the eof beat
- chk_valid  output  1  result valid
- chk_ready  input  1  result consumer ready
- chk_pass  output  1  computed CRC == in_exp_crc and no protocol error
- chk_crc  output  32  finalized computed CRC
- chk_err  output  1  protocol error seen in this frame (see Behaviour)

Behaviour:
- Reset: all outputs 0, except in_ready = 1. Running CRC = SEED. State = IDLE.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result transfers when chk_valid && chk_ready.
  - in_ready = !chk_valid || chk_ready. This stalls only while an unconsumed result is held.
- States:
  - IDLE: waiting for sof.
    - Accepted sof&!eof -> ACCUM.
    - Accepted sof&eof -> stays IDLE and produces a result.
    - Accepted beat without sof -> beat is ignored, err_pending is set, stays IDLE.
  - ACCUM: on each accepted beat, crc_r <= step(crc_r, in_data, in_sz).
    - eof -> IDLE with result.
    - sof in ACCUM: the old frame is abandoned with no result. CRC restarts from SEED over this beat. err_pending is set and is reported on the new frame's result.
- CRC step:
  - sof beats use SEED as the input CRC, otherwise crc_r.
  - Only in_sz bits are consumed.
  - in_sz=0 leaves the CRC unchanged.
  - in_sz>64 is treated as 64 and sets err_pending.
- Result:
  - Registered one cycle after the accepted eof beat: chk_crc = step_result ^ XOR_OUT.
  - chk_pass = (chk_crc == in_exp_crc) && !err.
  - chk_err = err_pending | this-beat error.
  - err_pending clears when the result is produced.
- Result hold: outputs remain stable while chk_valid && !chk_ready.
- Back-to-back frames: a result produced in the same cycle as the previous result is consumed is allowed; throughput is one beat per cycle.
- Asynchronous reset mid-frame: the frame is discarded and no result is produced.

Optional Feature:
- Macro: CR_XP10_DECOMP_CRC_CHK_STATS_EN.
- When defined, adds outputs stat_frames[31:0] and stat_fails[31:0].
  - stat_frames increments on each result transfer.
  - stat_fails increments on each result transfer with !chk_pass.
  - Both counters saturate at all-ones and reset to 0.
  - Also adds input stat_clr, a synchronous clear that takes priority over increment.
- When not defined, the ports and logic are absent.

Decomposition:
- Shared package cr_xp10_decompPKG holds:
  - CRC32C_POLY, CRC32C_SEED, CRC32C_XOR_OUT constants.
  - typedef crc_chk_state_e {IDLE, ACCUM}.
  - typedef struct crc_chk_result_t {pass, err, crc[31:0]}.
- Sub-module cr_xp10_decomp_crc32c_step: purely combinational. Inputs crc_in[31:0], data[63:0], sz[6:0]; output crc_out[31:0]. Bitwise reflected LFSR loop over 64 bits gated by bit index < sz. It is reused by the send-side CRC generator.

Test Plan:
- Single frame, ASCII "123456789": beat1 "12345678" sz=64 sof; beat2 "9" sz=8 eof, exp=32'hE3069283 -> chk_valid one cycle after beat2, chk_crc=32'hE3069283, pass=1, err=0.
- Same frame with exp=32'hE3069282 -> pass=0, err=0, chk_crc=32'hE3069283.
- Zero-size beat inserted mid-frame (sz=0) in the above frame -> identical result, pass=1.
- sof,eof single beat of 32 bytes impossible; instead sof with no eof, then new sof/eof frame "9" exp=32'hE3069283... -> old frame dropped, one result with err=1, pass=0. Also beat without sof in IDLE -> ignored, next frame reports err=1.
- Hold chk_ready=0 after a result while a second frame's eof arrives -> in_ready=0, eof beat stalled, first result stable; raise chk_ready -> result 1 transfers, eof accepted, result 2 appears next cycle.
- Assert rst_n low mid-frame -> chk_valid=0, in_ready=1. Next clean frame gives the correct CRC. With STATS_EN, 3 frames (1 fail) -> stat_frames=3, stat_fails=1; stat_clr -> 0.
